// File: rtl/rsa_host_loader_if.sv
// Stream and Avalon-MM bundle between the RSA host loader (master) and its
// word source, DRAM and engine flag register (slave).
interface rsa_host_loader_if;
    logic         st_valid;
    logic         st_ready;
    logic [31:0]  st_data;

    logic [31:0]  avm_m0_address;
    logic         avm_m0_write;
    logic [255:0] avm_m0_writedata;
    logic         avm_m0_waitrequest;

    logic         avm_m1_address;
    logic         avm_m1_write;
    logic         avm_m1_read;
    logic [7:0]   avm_m1_writedata;
    logic [7:0]   avm_m1_readdata;
    logic         avm_m1_waitrequest;

    modport master (
        input  st_valid, st_data,
        input  avm_m0_waitrequest,
        input  avm_m1_readdata, avm_m1_waitrequest,
        output st_ready,
        output avm_m0_address, avm_m0_write, avm_m0_writedata,
        output avm_m1_address, avm_m1_write, avm_m1_read, avm_m1_writedata
    );

    modport slave (
        output st_valid, st_data,
        output avm_m0_waitrequest,
        output avm_m1_readdata, avm_m1_waitrequest,
        input  st_ready,
        input  avm_m0_address, avm_m0_write, avm_m0_writedata,
        input  avm_m1_address, avm_m1_write, avm_m1_read, avm_m1_writedata
    );
endinterface

// File: rtl/rsa_host_loader.sv
// Packs a 32-bit job stream into 256-bit DRAM lines, kicks the RSA engine and
// polls its start flag. Define RSA_HOST_TIMEOUT_EN to bound polling with err.
module rsa_host_loader #(
    parameter logic [31:0] ADDR_BASE     = 32'd0,
    parameter int unsigned NUM_LINES     = 10,
    parameter int unsigned POLL_GAP      = 16,
    parameter int unsigned TIMEOUT_POLLS = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    rsa_host_loader_if.master  bus
);

    typedef enum logic [2:0] {IDLE, FILL, WRITE, KICK, GAP, POLL, DONE} state_t;

    state_t         state, state_nxt;
    logic [2:0]     word_cnt, word_cnt_nxt;
    logic [7:0]     line_cnt, line_cnt_nxt;
    logic [7:0]     gap_cnt, gap_cnt_nxt;
    logic [31:0]    poll_cnt, poll_cnt_nxt;
    logic [31:0]    addr_nxt;
    logic [255:0]   line_buf, line_buf_nxt;
    logic           beat;

    // st_ready is only ever high in FILL, so this is the FILL accept strobe.
    assign beat = bus.st_valid & bus.st_ready;

    assign bus.avm_m0_writedata = line_buf;
    assign bus.avm_m1_address   = 1'b0;
    assign bus.avm_m1_writedata = 8'h01;

`ifdef RSA_HOST_TIMEOUT_EN
    logic err_nxt;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        line_cnt_nxt = line_cnt;
        gap_cnt_nxt  = gap_cnt;
        poll_cnt_nxt = poll_cnt;
        addr_nxt     = bus.avm_m0_address;
        line_buf_nxt = line_buf;
`ifdef RSA_HOST_TIMEOUT_EN
        err_nxt      = err;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    word_cnt_nxt = 3'd0;
                    line_cnt_nxt = 8'd0;
                    poll_cnt_nxt = 32'd0;
                    addr_nxt     = ADDR_BASE;
`ifdef RSA_HOST_TIMEOUT_EN
                    err_nxt      = 1'b0;
`endif
                    state_nxt    = FILL;
                end
            end
            FILL: begin
                if (beat) begin
                    line_buf_nxt[{word_cnt, 5'd0} +: 32] = bus.st_data;
                    word_cnt_nxt = word_cnt + 3'd1;
                    if (word_cnt == 3'd7) state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!bus.avm_m0_waitrequest) begin
                    if (line_cnt == 8'(NUM_LINES - 1)) begin
                        state_nxt = KICK;
                    end else begin
                        line_cnt_nxt = line_cnt + 8'd1;
                        addr_nxt     = bus.avm_m0_address + 32'd32;
                        state_nxt    = FILL;
                    end
                end
            end
            KICK: begin
                if (!bus.avm_m1_waitrequest) begin
                    gap_cnt_nxt = 8'(POLL_GAP);
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_nxt = POLL;
                else                 gap_cnt_nxt = gap_cnt - 8'd1;
            end
            POLL: begin
                if (!bus.avm_m1_waitrequest) begin
                    if (!bus.avm_m1_readdata[0]) begin
                        state_nxt = DONE;
                    end
`ifdef RSA_HOST_TIMEOUT_EN
                    else if (poll_cnt == TIMEOUT_POLLS - 1) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
`endif
                    else begin
                        // Saturates so a stuck flag never wraps the attempt count.
                        if (poll_cnt != TIMEOUT_POLLS - 1) poll_cnt_nxt = poll_cnt + 32'd1;
                        gap_cnt_nxt = 8'(POLL_GAP);
                        state_nxt   = GAP;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe lines up with its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            word_cnt           <= 3'd0;
            line_cnt           <= 8'd0;
            gap_cnt            <= 8'd0;
            poll_cnt           <= 32'd0;
            // NOTE: the line buffer is reset because it drives writedata, which must read 0 out of reset.
            line_buf           <= '0;
            bus.avm_m0_address <= ADDR_BASE;
            bus.avm_m0_write   <= 1'b0;
            bus.avm_m1_write   <= 1'b0;
            bus.avm_m1_read    <= 1'b0;
            bus.st_ready       <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            state              <= state_nxt;
            word_cnt           <= word_cnt_nxt;
            line_cnt           <= line_cnt_nxt;
            gap_cnt            <= gap_cnt_nxt;
            poll_cnt           <= poll_cnt_nxt;
            line_buf           <= line_buf_nxt;
            bus.avm_m0_address <= addr_nxt;
            bus.avm_m0_write   <= (state_nxt == WRITE);
            bus.avm_m1_write   <= (state_nxt == KICK);
            bus.avm_m1_read    <= (state_nxt == POLL);
            bus.st_ready       <= (state_nxt == FILL);
            busy               <= (state_nxt != IDLE);
            done               <= (state_nxt == DONE);
        end
    end

`ifdef RSA_HOST_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err <= 1'b0;
        else          err <= err_nxt;
    end
`else
    assign err = 1'b0;
`endif

endmodule
